// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/op/a/b    request channels (N = 0 execute, 1 branch unit)
//   rspN_valid/ready           per-requester response handshake
//   rsp_result, rsp_illegal    shared response payload
//   alu_op/a/b, alu_result     shared ALU drive and return
//   last_grant                 index of the most recently accepted requester
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_illegal,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            last_grant
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic            r_ill;
    logic [OPW-1:0]  r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_res;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_idle;
    logic            w_acc;
    logic            w_take;
    logic            w_op_ok;
    logic [OPW-1:0]  w_sel_op;

    // On a tie the requester that did not win last time gets the ALU.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

    assign w_idle     = (r_state == IDLE);
    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;
    assign w_acc      = req0_ready || req1_ready;

    assign w_sel_op = w_gnt1 ? req1_op : req0_op;
    assign w_op_ok  = (w_sel_op <= OPW'(9));

    // Only the owner's ready can retire the response.
    assign w_take = r_owner ? rsp1_ready : rsp0_ready;

    assign rsp0_valid  = (r_state == RESP) && !r_owner;
    assign rsp1_valid  = (r_state == RESP) && r_owner;
    assign rsp_result  = r_res;
    assign rsp_illegal = r_ill;
    assign alu_op      = r_op;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign last_grant  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_ill   <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_owner <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_op    <= w_op_ok ? w_sel_op : '0;
                        r_ill   <= !w_op_ok;
                        r_a     <= w_gnt1 ? req1_a : req0_a;
                        r_b     <= w_gnt1 ? req1_b : req0_b;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res   <= alu_result;
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_take) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a transaction-level model
// of the arbiter and a behavioural ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_illegal;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        last_grant;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .last_grant(last_grant)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return {31'd0, $signed(a) < $signed(b)};
            4'd4: return {31'd0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int pick(input bit v0, input bit v1, input bit lst);
        if (v0 && v1) return lst ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Transaction model: busy flag, cycles since accept, expected payload.
    bit          m_busy;
    int          m_age;
    bit          m_last;
    bit          m_owner;
    bit          m_ill;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    int          q_gnt[$];
    int          q_cyc[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                int g;
                logic [3:0]  op;
                logic [31:0] a, b;
                g = pick(req0_valid, req1_valid, m_last);
                if (g >= 0) begin
                    op = (g == 1) ? req1_op : req0_op;
                    a  = (g == 1) ? req1_a : req0_a;
                    b  = (g == 1) ? req1_b : req0_b;
                    if (op > 4'd9) begin
                        m_ill <= 1'b1;
                        op = 4'd0;
                    end else begin
                        m_ill <= 1'b0;
                    end
                    m_op    <= op;
                    m_a     <= a;
                    m_b     <= b;
                    m_res   <= alu_f(op, a, b);
                    m_owner <= (g == 1);
                    m_last  <= (g == 1);
                    m_busy  <= 1'b1;
                    m_age   <= 1;
                    q_gnt.push_back(g);
                    q_cyc.push_back(cyc);
                end
            end else if (m_age == 1) begin
                m_age <= 2;
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    logic [31:0] q_r0[$];
    logic [31:0] q_r1[$];
    int          n_rsp0 = 0;

    always @(negedge clk) begin
        int  g;
        bit  rsp;
        g   = pick(req0_valid, req1_valid, m_last);
        rsp = m_busy && (m_age == 2);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, !m_busy && g == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, !m_busy && g == 1});
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, rsp && !m_owner});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, rsp && m_owner});
        chk("last_grant", {31'd0, last_grant}, {31'd0, m_last});
        if (rsp) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, m_ill});
        end
        if (m_busy && m_age == 1) begin
            chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
        end
        if (rsp0_valid) n_rsp0++;
        if (rsp0_valid && rsp0_ready) q_r0.push_back(rsp_result);
        if (rsp1_valid && rsp1_ready) q_r1.push_back(rsp_result);
    end

    // Drives one request and returns #1 after its accept edge.
    task automatic issue(input int r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        if (r == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, b1, bg, base;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;

        // 1: reset values
        #12;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
        chk("idle_ready1", {31'd0, req1_ready}, 32'd0);

        // 2: simple add on requester 0
        issue(0, 4'd0, 32'd5, 32'd7);
        chk("t2_alu_op", {28'd0, alu_op}, 32'd0);
        chk("t2_alu_a", alu_a, 32'd5);
        chk("t2_alu_b", alu_b, 32'd7);
        step(1);
        chk("t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("t2_result", rsp_result, 32'd12);
        chk("t2_illegal", {31'd0, rsp_illegal}, 32'd0);
        chk("t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        step(2);

        // 4: backpressure on requester 1 (restores last_grant=1)
        rsp1_ready = 1'b0;
        issue(1, 4'd7, 32'h8000_0000, 32'd4);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 1; req0_b = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("t4_result", rsp_result, 32'hF800_0000);
            chk("t4_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        step(1);
        chk("t4_done", {31'd0, rsp1_valid}, 32'd0);
        step(1);

        // 3: continuous tie, grants alternate
        b0 = q_r0.size(); b1 = q_r1.size(); bg = q_gnt.size();
        req0_valid = 1; req0_op = 4'd1; req0_a = 10; req0_b = 3;
        req1_valid = 1; req1_op = 4'd9; req1_a = 32'hF0; req1_b = 32'h3C;
        step(7);
        req0_valid = 0; req1_valid = 0;
        step(3);
        chk("t3_ngrants", q_gnt.size() - bg, 32'd3);
        if (q_gnt.size() - bg == 3) begin
            chk("t3_g0", q_gnt[bg], 32'd0);
            chk("t3_g1", q_gnt[bg + 1], 32'd1);
            chk("t3_g2", q_gnt[bg + 2], 32'd0);
            chk("t3_gap1", q_cyc[bg + 1] - q_cyc[bg], 32'd3);
            chk("t3_gap2", q_cyc[bg + 2] - q_cyc[bg + 1], 32'd3);
        end
        chk("t3_nr0", q_r0.size() - b0, 32'd2);
        chk("t3_nr1", q_r1.size() - b1, 32'd1);
        if (q_r0.size() > b0) chk("t3_r0", q_r0[b0], 32'd7);
        if (q_r1.size() > b1) chk("t3_r1", q_r1[b1], 32'h30);

        // 5: illegal op
        issue(0, 4'd12, 32'd2, 32'd3);
        chk("t5_alu_op", {28'd0, alu_op}, 32'd0);
        step(1);
        chk("t5_result", rsp_result, 32'd5);
        chk("t5_illegal", {31'd0, rsp_illegal}, 32'd1);
        step(2);

        // 6: reset during EXEC
        issue(0, 4'd0, 32'd1, 32'd1);
        base = n_rsp0;
        rst_n = 1'b0;
        #2;
        chk("t6_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("t6_last_grant", {31'd0, last_grant}, 32'd1);
        chk("t6_rsp_result", rsp_result, 32'd0);
        #4;
        rst_n = 1'b1;
        step(3);
        chk("t6_no_rsp0", n_rsp0 - base, 32'd0);
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("t6_tie_ready0", {31'd0, req0_ready}, 32'd1);
        chk("t6_tie_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
